// File: rtl/dhash_motion_reader_pkg.sv
// Shared types and sizes for the dHash motion reader: FSM states, signature geometry
// and the widths of the distance accumulator and per-word popcount.
package dhash_motion_reader_pkg;

  localparam int SIG_WORDS = 4;
  localparam int SIG_BITS  = 128;
  localparam int DIST_W    = 8;
  localparam int POP_W     = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ISSUE,
    ST_WAIT,
    ST_ACCUM,
    ST_DONE
  } state_e;

endpackage

// File: rtl/dhash_motion_reader_popcount32.sv
// Combinational ones counter for one 32-bit signature word (0..32).
// Zero latency; no flow control.
module dhash_motion_reader_popcount32
  import dhash_motion_reader_pkg::*;
(
  input  logic [31:0]      word_i,
  output logic [POP_W-1:0] count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < 32; i++) begin
      count_o = count_o + POP_W'(word_i[i]);
    end
  end

endmodule

// File: rtl/dhash_motion_reader.sv
// Fetches the 128-bit dHash signature as four custom-instruction reads per frame and reports
// the Hamming distance to the previous frame; a stalled read aborts the frame after timeoutCycles.
module dhash_motion_reader
  import dhash_motion_reader_pkg::*;
#(
  parameter logic [7:0] customId      = 8'd0,
  parameter logic [7:0] timeoutCycles = 8'd255
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic              frameReady_i,
  input  logic [7:0]        threshold_i,
  output logic              ciStart_o,
  output logic [7:0]        ciN_o,
  output logic [31:0]       ciValueA_o,
  output logic [31:0]       ciValueB_o,
  input  logic [31:0]       ciResult_i,
  input  logic              ciDone_i,
  output logic [DIST_W-1:0] distance_o,
  output logic              distanceValid_o,
  output logic              motion_o,
  output logic              busy_o,
  output logic              ciTimeout_o,
  output logic [7:0]        droppedFrames_o
);

  state_e              state_q, state_d;
  logic                pending_q, pending_d;
  logic [1:0]          k_q, k_d;
  logic [7:0]          wait_cnt_q, wait_cnt_d;
  logic [DIST_W-1:0]   acc_q, acc_d;
  logic [31:0]         cur_word_q, cur_word_d;
  logic [SIG_BITS-1:0] new_sig_q, new_sig_d;
  logic [SIG_BITS-1:0] prev_sig_q, prev_sig_d;
  logic                first_frame_q, first_frame_d;
  logic                ci_start_q, ci_start_d;
  logic [1:0]          ci_addr_q, ci_addr_d;
  logic [DIST_W-1:0]   distance_q, distance_d;
  logic                dist_vld_q, dist_vld_d;
  logic                motion_q, motion_d;
  logic                busy_q, busy_d;
  logic                timeout_q, timeout_d;
  logic [7:0]          dropped_q, dropped_d;

  logic [31:0]         word_diff;
  logic [POP_W-1:0]    word_pop;
  logic                frame_req;

  assign frame_req = frameReady_i && enable_i;
  assign word_diff = cur_word_q ^ prev_sig_q[{k_q, 5'd0} +: 32];

  dhash_motion_reader_popcount32 u_popcount (
    .word_i  (word_diff),
    .count_o (word_pop)
  );

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    k_d           = k_q;
    wait_cnt_d    = wait_cnt_q;
    acc_d         = acc_q;
    cur_word_d    = cur_word_q;
    new_sig_d     = new_sig_q;
    prev_sig_d    = prev_sig_q;
    first_frame_d = first_frame_q;
    distance_d    = distance_q;
    dist_vld_d    = 1'b0;
    motion_d      = motion_q;
    timeout_d     = timeout_q;
    dropped_d     = dropped_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pending_q) begin
          pending_d = 1'b0;
          acc_d     = '0;
          k_d       = '0;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        wait_cnt_d = '0;
        state_d    = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (ciDone_i) begin
          cur_word_d = ciResult_i;
          state_d    = ST_ACCUM;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (ciDone_i) begin
          cur_word_d = ciResult_i;
          state_d    = ST_ACCUM;
        end else if (wait_cnt_q + 8'd1 >= timeoutCycles) begin
          // Abort: prevSig keeps the last complete signature.
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ST_ACCUM: begin
        acc_d = acc_q + DIST_W'(word_pop);
        new_sig_d[{k_q, 5'd0} +: 32] = cur_word_q;
        if (k_q == 2'(SIG_WORDS - 1)) begin
          state_d = ST_DONE;
        end else begin
          k_d     = k_q + 2'd1;
          state_d = ST_SETUP;
        end
      end
      ST_DONE: begin
        prev_sig_d = new_sig_q;
        if (first_frame_q) begin
          first_frame_d = 1'b0;
        end else begin
          distance_d = acc_q;
          motion_d   = (acc_q > threshold_i);
          dist_vld_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A new request wins over the IDLE clear so a pulse in that cycle is not lost.
    if (frame_req) begin
      if (pending_q && state_q != ST_IDLE) begin
        if (dropped_q != 8'hFF) dropped_d = dropped_q + 8'd1;
      end else begin
        pending_d = 1'b1;
      end
    end

    ci_start_d = (state_d == ST_ISSUE);
    ci_addr_d  = (state_d == ST_SETUP) ? k_d : ci_addr_q;
    busy_d     = (state_q != ST_IDLE);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      pending_q     <= 1'b0;
      k_q           <= '0;
      wait_cnt_q    <= '0;
      acc_q         <= '0;
      cur_word_q    <= '0;
      new_sig_q     <= '0;
      prev_sig_q    <= '0;
      first_frame_q <= 1'b1;
      ci_start_q    <= 1'b0;
      ci_addr_q     <= '0;
      distance_q    <= '0;
      dist_vld_q    <= 1'b0;
      motion_q      <= 1'b0;
      busy_q        <= 1'b0;
      timeout_q     <= 1'b0;
      dropped_q     <= '0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      k_q           <= k_d;
      wait_cnt_q    <= wait_cnt_d;
      acc_q         <= acc_d;
      cur_word_q    <= cur_word_d;
      new_sig_q     <= new_sig_d;
      prev_sig_q    <= prev_sig_d;
      first_frame_q <= first_frame_d;
      ci_start_q    <= ci_start_d;
      ci_addr_q     <= ci_addr_d;
      distance_q    <= distance_d;
      dist_vld_q    <= dist_vld_d;
      motion_q      <= motion_d;
      busy_q        <= busy_d;
      timeout_q     <= timeout_d;
      dropped_q     <= dropped_d;
    end
  end

  assign ciStart_o       = ci_start_q;
  assign ciN_o           = customId;
  assign ciValueA_o      = {30'd0, ci_addr_q};
  assign ciValueB_o      = '0;
  assign distance_o      = distance_q;
  assign distanceValid_o = dist_vld_q;
  assign motion_o        = motion_q;
  assign busy_o          = busy_q;
  assign ciTimeout_o     = timeout_q;
  assign droppedFrames_o = dropped_q;

endmodule

// File: tb/tb_dhash_motion_reader.sv
// Directed bench for dhash_motion_reader with a behavioural custom-instruction responder.
module tb_dhash_motion_reader;

  logic        clk = 1'b0;
  logic        reset, enable, frameReady;
  logic [7:0]  threshold;
  logic        ciStart_o, ciDone;
  logic [7:0]  ciN_o;
  logic [31:0] ciValueA_o, ciValueB_o, ciResult;
  logic [7:0]  distance_o, droppedFrames_o;
  logic        distanceValid_o, motion_o, busy_o, ciTimeout_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dhash_motion_reader #(.customId(8'hA5), .timeoutCycles(8'd8)) dut (
    .clock_i         (clk),
    .reset_i         (reset),
    .enable_i        (enable),
    .frameReady_i    (frameReady),
    .threshold_i     (threshold),
    .ciStart_o       (ciStart_o),
    .ciN_o           (ciN_o),
    .ciValueA_o      (ciValueA_o),
    .ciValueB_o      (ciValueB_o),
    .ciResult_i      (ciResult),
    .ciDone_i        (ciDone),
    .distance_o      (distance_o),
    .distanceValid_o (distanceValid_o),
    .motion_o        (motion_o),
    .busy_o          (busy_o),
    .ciTimeout_o     (ciTimeout_o),
    .droppedFrames_o (droppedFrames_o)
  );

  // Responder: returns sig_mem[addr]; ciDone with ciStart (delay 0) or resp_delay cycles later.
  logic [31:0] sig_mem [4];
  int          resp_delay = 0;
  int          withhold_word = -1;
  int          since = 0;
  logic        active = 1'b0;
  logic        withheld;

  assign withheld = (withhold_word == int'(ciValueA_o[1:0]));
  assign ciResult = sig_mem[ciValueA_o[1:0]];
  assign ciDone   = !withheld && ((resp_delay == 0) ? ciStart_o : (active && since == resp_delay));

  always @(posedge clk) begin
    if (reset) begin
      active <= 1'b0;
    end else if (ciStart_o && !ciDone) begin
      active <= 1'b1;
      since  <= 1;
    end else if (active) begin
      if (ciDone) active <= 1'b0;
      else        since  <= since + 1;
    end
  end

  // Protocol monitor: ciStart pulse count, back-to-back starts, ciValueA movement while a read is open.
  int          starts_total = 0;
  int          consec_total = 0;
  int          va_viol = 0;
  logic        prev_start = 1'b0;
  logic        hold_active = 1'b0;
  logic [31:0] hold_val = '0;

  always @(negedge clk) begin
    if (ciStart_o) starts_total <= starts_total + 1;
    if (ciStart_o && prev_start) consec_total <= consec_total + 1;
    prev_start <= ciStart_o;
    if (reset || !busy_o && !ciStart_o) begin
      hold_active <= 1'b0;
    end else begin
      if (hold_active && ciValueA_o != hold_val) va_viol <= va_viol + 1;
      if (ciDone) begin
        hold_active <= 1'b0;
      end else if (ciStart_o) begin
        hold_active <= 1'b1;
        hold_val    <= ciValueA_o;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_sig(input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] w2, input logic [31:0] w3);
    sig_mem[0] = w0; sig_mem[1] = w1; sig_mem[2] = w2; sig_mem[3] = w3;
  endtask

  // Pulses frameReady in cycle t; k counts cycles after t, sampled at negedges.
  task automatic run_frame(output int dv_at, output int n_dv, output logic done);
    dv_at = -1; n_dv = 0; done = 1'b0;
    frameReady = 1'b1;
    @(negedge clk);
    frameReady = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      if (distanceValid_o) begin
        n_dv++;
        if (dv_at < 0) dv_at = k;
      end
      if (k >= 4 && !busy_o) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1;
  endtask

  int   dv_at, n_dv, s0, dv_cnt;
  logic done;

  initial begin
    reset = 1'b1; enable = 1'b1; frameReady = 1'b0; threshold = 8'd4;
    set_sig('0, '0, '0, '0);
    repeat (3) @(negedge clk);
    check("rst_ciStart", ciStart_o, 0);
    check("rst_ciN", ciN_o, 8'hA5);
    check("rst_ciValueA", ciValueA_o, 0);
    check("rst_ciValueB", ciValueB_o, 0);
    check("rst_distance", distance_o, 0);
    check("rst_dvalid", distanceValid_o, 0);
    check("rst_motion", motion_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_timeout", ciTimeout_o, 0);
    check("rst_dropped", droppedFrames_o, 0);
    reset = 1'b0;
    @(negedge clk);

    // First frame after reset only primes prevSig.
    s0 = starts_total;
    run_frame(dv_at, n_dv, done);
    check("f1_done", done, 1);
    check("f1_no_dv", n_dv, 0);
    check("f1_starts", starts_total - s0, 4);

    set_sig('0, '0, 32'h0000_000F, '0);
    run_frame(dv_at, n_dv, done);
    check("f2_dv_at", dv_at, 15);
    check("f2_n_dv", n_dv, 1);
    check("f2_distance", distance_o, 4);
    check("f2_motion_eq_thr", motion_o, 0);

    threshold = 8'd3;
    set_sig('0, '0, '0, '0);
    run_frame(dv_at, n_dv, done);
    check("f3_distance", distance_o, 4);
    check("f3_motion_gt_thr", motion_o, 1);

    threshold = 8'd100;
    set_sig('1, '1, '1, '1);
    run_frame(dv_at, n_dv, done);
    check("f4_distance_max", distance_o, 128);
    check("f4_motion", motion_o, 1);

    // Late ciDone: 5 WAIT cycles per word.
    resp_delay = 5;
    set_sig(32'hFFFF_FF00, '1, '1, '1);
    s0 = starts_total;
    run_frame(dv_at, n_dv, done);
    check("f5_dv_at", dv_at, 35);
    check("f5_distance", distance_o, 8);
    check("f5_motion", motion_o, 0);
    check("f5_starts", starts_total - s0, 4);
    check("f5_va_stable", va_viol, 0);

    // enable low: request ignored.
    enable = 1'b0;
    frameReady = 1'b1;
    @(negedge clk);
    frameReady = 1'b0;
    repeat (3) @(negedge clk);
    check("en_low_busy", busy_o, 0);
    check("en_low_dropped", droppedFrames_o, 0);
    enable = 1'b1;
    @(negedge clk);

    // Word 1 never completes.
    resp_delay = 0;
    withhold_word = 1;
    set_sig('0, '0, '0, '0);
    s0 = starts_total;
    run_frame(dv_at, n_dv, done);
    check("to_done", done, 1);
    check("to_no_dv", n_dv, 0);
    check("to_flag", ciTimeout_o, 1);
    check("to_busy", busy_o, 0);
    check("to_starts", starts_total - s0, 2);
    check("to_distance_kept", distance_o, 8);

    // Compare against the last complete signature {FFFFFF00, 1s, 1s, 1s}.
    withhold_word = -1;
    threshold = 8'd7;
    set_sig('1, '1, '1, '1);
    run_frame(dv_at, n_dv, done);
    check("post_to_dv", n_dv, 1);
    check("post_to_distance", distance_o, 8);
    check("post_to_motion", motion_o, 1);
    check("post_to_sticky", ciTimeout_o, 1);

    // Overrun: pulses at t, t+3, t+5.
    dv_cnt = 0;
    frameReady = 1'b1; @(negedge clk);
    frameReady = 1'b0; @(negedge clk);
    @(negedge clk);
    frameReady = 1'b1; @(negedge clk);
    frameReady = 1'b0; @(negedge clk);
    frameReady = 1'b1; @(negedge clk);
    frameReady = 1'b0;
    for (int k = 6; k <= 80; k++) begin
      if (distanceValid_o) dv_cnt++;
      @(negedge clk);
    end
    check("ovr_dropped", droppedFrames_o, 1);
    check("ovr_dv_count", dv_cnt, 2);
    check("ovr_distance", distance_o, 0);
    check("ovr_motion", motion_o, 0);
    check("ovr_busy", busy_o, 0);

    // Reset during WAIT of word 2 (cycle t+21 with 5-cycle responder delay).
    resp_delay = 5;
    frameReady = 1'b1; @(negedge clk);
    frameReady = 1'b0;
    repeat (20) @(negedge clk);
    check("mid_addr_word2", ciValueA_o, 2);
    check("mid_busy", busy_o, 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_ciStart", ciStart_o, 0);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_timeout", ciTimeout_o, 0);
    check("mid_rst_dropped", droppedFrames_o, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    resp_delay = 0;
    threshold = 8'd29;
    run_frame(dv_at, n_dv, done);
    check("rr_first_done", done, 1);
    check("rr_first_no_dv", n_dv, 0);
    check("rr_first_distance", distance_o, 0);

    set_sig('1, '1, '1, 32'h8000_0001);
    run_frame(dv_at, n_dv, done);
    check("rr_dv_at", dv_at, 15);
    check("rr_distance", distance_o, 30);
    check("rr_motion", motion_o, 1);

    check("no_consec_start", consec_total, 0);
    check("va_stable_total", va_viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dhash_motion_reader.md
# dhash_motion_reader

Hardware initiator for the custom-instruction read port of the dHash signature engine. On each new-frame indication it fetches the 128-bit frame signature as four 32-bit custom-instruction reads and computes the Hamming distance to the previous frame's signature. It flags motion when that distance exceeds a programmable threshold, so the CPU is no longer needed in the per-frame compare loop.

## Interface
- customId, 8'd0, value driven on ciN; must match the responder's customId
- timeoutCycles, 8'd255, maximum WAIT cycles for ciDone before the frame is aborted
- clock  in  1  system clock; the only clock. Responder read port and frameReady are in this domain
- reset  in  1  synchronous, active-high
- enable  in  1  when low, frameReady is ignored and no new frame is accepted
- frameReady  in  1  single-cycle pulse: a new signature is complete in the responder
- threshold  in  8  motion threshold, sampled in the DONE cycle
- ciStart  out  1  one-cycle request pulse
- ciN  out  8  instruction id, constant customId
- ciValueA  out  32  word address in bits [1:0], upper bits 0
- ciValueB  out  32  constant 0
- ciResult  in  32  read data, valid in the cycle ciDone=1
- ciDone  in  1  completion; may coincide with ciStart or come later
- distance  out  8  Hamming distance, 0..128
- distanceValid  out  1  one-cycle pulse when distance and motion are updated
- motion  out  1  distance > threshold (strict), held until next update
- busy  out  1  high in every state except IDLE
- ciTimeout  out  1  sticky; set on an aborted read, cleared only by reset
- droppedFrames  out  8  saturating count of frameReady pulses lost to overrun

## Operation
- All outputs are registered. Reset values are 0 for all outputs except ciN=customId; state is IDLE.
- States: IDLE, SETUP, ISSUE, WAIT, ACCUM, DONE.
- Pending flag: frameReady with enable=1 sets pending. If pending is already set and the FSM is not in IDLE, the pulse is dropped and droppedFrames increments (saturating at 255).
- IDLE: if pending, clear it, zero the accumulator and word index k, go to SETUP.
- SETUP: ciValueA=k, ciStart=0. The extra cycle covers the responder's synchronous RAM read; next state is ISSUE.
- ISSUE: ciStart=1, ciValueA held at k.
  - If ciDone, capture ciResult into curWord and go to ACCUM.
  - Otherwise go to WAIT.
- WAIT: ciValueA held, ciStart=0, timeout counter increments.
  - If ciDone, capture and go to ACCUM.
  - If the counter reaches timeoutCycles, set ciTimeout, leave prevSig untouched, drop the partial result and go to IDLE.
- ACCUM: accumulator += popcount(curWord XOR prevSig[32k+31:32k]); newSig[32k+31:32k] = curWord.
  - If k=3, go to DONE.
  - Otherwise k+1 and go to SETUP.
- DONE: prevSig <= newSig.
  - If firstFrame is set, clear it and suppress the output: no distanceValid pulse, and distance/motion are unchanged.
  - Otherwise distance <= accumulator, motion <= (accumulator > threshold), distanceValid=1.
  - Next state is IDLE.
- Width rules: popcount is 6 bits (0..32); the accumulator is 8 bits and cannot overflow (maximum 128). The comparison is unsigned.
- Reset mid-frame: ciStart is 0 on the next cycle, pending, prevSig and counters are cleared, and firstFrame=1.

## Timing
- frameReady sampled at edge t with the FSM in IDLE and pending clear: pending=1 at t+1, SETUP at t+2.
- Each word costs 3 cycles when ciDone coincides with ciStart, plus n WAIT cycles when ciDone is late.
- With zero-wait ciDone, distanceValid is high in cycle t+15 (DONE), and busy falls after that cycle.
- A frameReady in the DONE cycle sets pending; the next frame enters SETUP 2 cycles later with no drop.
- ciStart is never high on two consecutive cycles.
- ciValueA changes only in SETUP.

## Structure
- Shared package holds:
  - the state enum
  - sigWords=4 and sigBits=128
  - distance width 8 and popcount width 6
- Sub-module popcount32: combinational 32-bit ones counter with a 6-bit output, used in ACCUM.
- Everything else lives in a single module.

## Test plan
- Reset, then two frames of signature 0 then 0x0000_000F in word 2, ciDone same cycle. Required response:
  - no distanceValid for frame 1
  - frame 2: distance=4, motion=0 with threshold=4, distanceValid at t+15
- Frames all-zero then all-ones, threshold=100 -> distance=128, motion=1.
- ciDone delayed 5 cycles on every read -> distanceValid at t+35. ciValueA is stable through each WAIT, and exactly four ciStart pulses occur.
- ciDone withheld on word 1, timeoutCycles=8 -> ciTimeout=1, no distanceValid, busy low. The next frame compares against the last good prevSig.
- Overrun: frameReady pulses at t, t+3 and t+5 -> pending holds one frame, droppedFrames=1, and two distanceValid pulses occur.
- Reset asserted in WAIT of word 2 -> ciStart=0 and busy=0 next cycle. The following frame produces no distanceValid (firstFrame behaviour).
